fetch_ctrl: RTL and testbench
=============================

// Module: fetch_ctrl
// PURPOSE
//  Sequencer for the IF program-counter stage: boots it at a start address and gates it with pipeline stalls.
//  Delivers branch redirects, holding any redirect that arrives during a stall, and stops fetch on a decoded halt.
//  Sits between top-level control/ID-EX branch resolution and the IF block; drives all IF control inputs.
// PARAMETERS
//  A   4   instruction address width (matches IF)
//  CW  16  run-cycle counter width
// PORTS
//  clk            in   1   clock
//  reset          in   1   reset, synchronous, active-high
//  start          in   1   start pulse; accepted in IDLE or HALTED only
//  start_addr     in   A   boot address, sampled when start accepted
//  br_valid       in   1   branch resolved this cycle
//  br_taken       in   1   resolved branch is taken (qualified by br_valid)
//  br_target      in   A   redirect address
//  stall          in   1   pipeline hazard: freeze PC this cycle
//  halt_inst      in   1   halt instruction decoded this cycle
//  if_reset       out  1   to IF reset: load if_addr
//  if_halt        out  1   to IF halt: hold PC
//  if_ctrl_branch out  1   to IF ctrl_branch
//  if_take_branch out  1   to IF take_branch
//  if_addr        out  A   to IF inst_addr_in
//  busy           out  1   state is LOAD or RUN
//  done           out  1   state is HALTED
//  cycle_count    out  CW  cycles spent in RUN
// BEHAVIOUR
//  States: IDLE, LOAD, RUN, HALTED. Reset -> IDLE; pend=0, pend_addr=0, start_addr_q=0, cycle_count=0.
//  IDLE:   if_halt=1; start -> latch start_addr_q, clear cycle_count, go to LOAD.
//  LOAD:   one cycle; if_reset=1, if_addr=start_addr_q; then unconditionally RUN.
//  RUN:    if_halt = stall | halt_inst; halt_inst -> HALTED (PC frozen that same cycle); start ignored.
//  HALTED: if_halt=1, done=1; start -> same as in IDLE.
//  if_reset = reset | (state==LOAD). While reset is high, if_addr=0, so the IF PC clears with the controller.
//  Redirect issue (RUN only): if_ctrl_branch = if_take_branch = 1 and if_addr = target; all other cycles both are 0.
//  The IF PC equals the target on the following cycle.
//  Redirect priority in RUN, per cycle:
//   1. halt_inst=1: no redirect issued; pend cleared; any incoming branch dropped.
//   2. stall=1 with br_valid&br_taken: pend<=1, pend_addr<=br_target. Overwrites an older pending redirect; nothing issued.
//   3. stall=1 otherwise: pend is held.
//   4. stall=0 with br_valid&br_taken: issue br_target; pend<=0. The new branch beats the pending one.
//   5. stall=0 with pend=1: issue pend_addr; pend<=0.
//   6. Otherwise: no redirect; IF increments.
//  br_valid with br_taken=0 never redirects and does not touch pend.
//  Leaving RUN for any reason clears pend.
//  cycle_count: +1 on every RUN cycle, including stall and halt_inst cycles. Saturates at 2^CW-1; held in IDLE and HALTED.
//  Reset mid-operation: on the next edge the controller returns to IDLE and the IF PC returns to 0; all in-flight redirects are lost.
//  Outputs are combinational from the state and inputs; the controller adds no latency beyond the IF register.
// TESTING
//  Boot: reset, then start with start_addr=5 -> LOAD 1 cycle; pc_cur 5,6,7 on successive RUN cycles; busy=1.
//  Taken branch: in RUN at pc=7, br_valid=1, br_taken=1, br_target=2, stall=0 -> next pc=2, then 3.
//  Held redirect: stall=1 for 3 cycles; taken branch to 9 in stall cycle 1, then to 12 in stall cycle 2
//   -> pc frozen during the stall; first cycle after the stall issues 12; pc=12, then 13.
//  Halt: halt_inst at pc=4 with a simultaneous taken branch to 0 -> pc stays 4; done=1; cycle_count frozen;
//   a restart with start_addr=1 clears cycle_count and PC boots at 1.
//  Saturation (CW=3): 10 RUN cycles -> cycle_count stops at 7.
//  Reset mid-run with pend=1 -> IDLE, pc=0, pend=0; no redirect issued after the next start.

Source files
------------

// File: rtl/fetch_ctrl.sv
// IF-stage sequencer: boots the PC at a start address, gates it with stalls,
// delivers (or holds across a stall) branch redirects and stops fetch on halt.
module fetch_ctrl #(
  parameter int A  = 4,
  parameter int CW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [A-1:0]  start_addr,
  input  logic          br_valid,
  input  logic          br_taken,
  input  logic [A-1:0]  br_target,
  input  logic          stall,
  input  logic          halt_inst,
  output logic          if_reset,
  output logic          if_halt,
  output logic          if_ctrl_branch,
  output logic          if_take_branch,
  output logic [A-1:0]  if_addr,
  output logic          busy,
  output logic          done,
  output logic [CW-1:0] cycle_count
);

  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_RUN, S_HALTED} state_t;

  state_t        r_state, w_state_nxt;
  logic          r_pend, w_pend_nxt;
  logic [A-1:0]  r_pend_addr, w_pend_addr_nxt;
  logic [A-1:0]  r_start_addr_q;
  logic [CW-1:0] r_cycle_count;

  logic          w_br;
  logic          w_start_acc;
  logic          w_load;
  logic          w_redirect;
  logic [A-1:0]  w_redirect_addr;

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (&v) ? v : v + CW'(1);
  endfunction

  assign w_br = br_valid & br_taken;

  always_comb begin
    w_state_nxt     = r_state;
    w_pend_nxt      = r_pend;
    w_pend_addr_nxt = r_pend_addr;
    w_start_acc     = 1'b0;
    w_load          = 1'b0;
    w_redirect      = 1'b0;
    w_redirect_addr = '0;
    if_halt         = 1'b0;
    case (r_state)
      S_IDLE, S_HALTED: begin
        if_halt    = 1'b1;
        w_pend_nxt = 1'b0;
        if (start) begin
          w_start_acc = 1'b1;
          w_state_nxt = S_LOAD;
        end
      end
      S_LOAD: begin
        w_load      = 1'b1;
        w_pend_nxt  = 1'b0;
        w_state_nxt = S_RUN;
      end
      S_RUN: begin
        if_halt = stall | halt_inst;
        if (halt_inst) begin
          w_pend_nxt  = 1'b0;
          w_state_nxt = S_HALTED;
        end else if (stall) begin
          // Latest taken branch during a stall replaces any older held one.
          if (w_br) begin
            w_pend_nxt      = 1'b1;
            w_pend_addr_nxt = br_target;
          end
        end else if (w_br) begin
          w_redirect      = 1'b1;
          w_redirect_addr = br_target;
          w_pend_nxt      = 1'b0;
        end else if (r_pend) begin
          w_redirect      = 1'b1;
          w_redirect_addr = r_pend_addr;
          w_pend_nxt      = 1'b0;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // IF reset must follow the controller reset so the PC clears alongside it.
  assign if_reset       = reset | w_load;
  assign if_ctrl_branch = w_redirect;
  assign if_take_branch = w_redirect;
  assign if_addr        = reset  ? '0 :
                          w_load ? r_start_addr_q :
                          w_redirect_addr;
  assign busy           = (r_state == S_LOAD) || (r_state == S_RUN);
  assign done           = (r_state == S_HALTED);
  assign cycle_count    = r_cycle_count;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state        <= S_IDLE;
      r_pend         <= 1'b0;
      r_pend_addr    <= '0;
      r_start_addr_q <= '0;
      r_cycle_count  <= '0;
    end else begin
      r_state     <= w_state_nxt;
      r_pend      <= w_pend_nxt;
      r_pend_addr <= w_pend_addr_nxt;
      if (w_start_acc) begin
        r_start_addr_q <= start_addr;
        r_cycle_count  <= '0;
      end else if (r_state == S_RUN) begin
        r_cycle_count <= sat_inc(r_cycle_count);
      end
    end
  end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Bench for fetch_ctrl: directed vector table plus randomized traffic checked
// against a transaction-level model of the controller and the IF PC it drives.
module tb_fetch_ctrl;

  logic       clk;
  logic       reset, start, br_valid, br_taken, stall, halt_inst;
  logic [3:0] start_addr, br_target;
  logic       if_reset, if_halt, if_ctrl_branch, if_take_branch, busy, done;
  logic [3:0] if_addr;
  logic [2:0] cycle_count;

  fetch_ctrl #(.A(4), .CW(3)) dut (
    .clk(clk), .reset(reset), .start(start), .start_addr(start_addr),
    .br_valid(br_valid), .br_taken(br_taken), .br_target(br_target),
    .stall(stall), .halt_inst(halt_inst),
    .if_reset(if_reset), .if_halt(if_halt), .if_ctrl_branch(if_ctrl_branch),
    .if_take_branch(if_take_branch), .if_addr(if_addr),
    .busy(busy), .done(done), .cycle_count(cycle_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Simple IF stage driven by the DUT outputs.
  logic [3:0] pc_cur;
  always @(posedge clk) begin
    if (if_reset)                             pc_cur <= if_addr;
    else if (!if_halt && if_ctrl_branch && if_take_branch) pc_cur <= if_addr;
    else if (!if_halt)                        pc_cur <= pc_cur + 4'd1;
  end

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: phase of operation, a queue holding at most one held redirect.
  localparam int PH_IDLE = 0, PH_BOOT = 1, PH_RUN = 2, PH_STOP = 3;
  int         m_phase;
  logic [3:0] m_boot, m_pc;
  logic [3:0] m_held[$];
  int         m_runs;
  logic       e_rst, e_halt, e_br, e_busy, e_done;
  logic [3:0] e_addr;

  task automatic model_eval();
    e_rst  = reset || (m_phase == PH_BOOT);
    e_br   = 1'b0;
    e_addr = 4'd0;
    if (m_phase == PH_BOOT) e_addr = m_boot;
    if (m_phase == PH_RUN && !halt_inst && !stall) begin
      if (br_valid && br_taken) begin e_br = 1'b1; e_addr = br_target; end
      else if (m_held.size() > 0) begin e_br = 1'b1; e_addr = m_held[0]; end
    end
    if (reset) e_addr = 4'd0;
    e_halt = (m_phase == PH_IDLE || m_phase == PH_STOP) ||
             (m_phase == PH_RUN && (stall || halt_inst));
    e_busy = (m_phase == PH_BOOT || m_phase == PH_RUN);
    e_done = (m_phase == PH_STOP);
  endtask

  task automatic model_step();
    model_eval();
    if (reset) begin
      m_phase = PH_IDLE; m_held.delete(); m_boot = 4'd0; m_runs = 0; m_pc = 4'd0;
    end else begin
      case (m_phase)
        PH_IDLE, PH_STOP:
          if (start) begin m_boot = start_addr; m_runs = 0; m_phase = PH_BOOT; end
        PH_BOOT: begin m_pc = m_boot; m_phase = PH_RUN; end
        default: begin
          if (m_runs < 7) m_runs++;
          if (halt_inst) begin
            m_held.delete(); m_phase = PH_STOP;
          end else if (stall) begin
            if (br_valid && br_taken) begin m_held.delete(); m_held.push_back(br_target); end
          end else begin
            m_pc = e_br ? e_addr : m_pc + 4'd1;
            m_held.delete();
          end
        end
      endcase
    end
  endtask

  task automatic check_model();
    model_eval();
    chk("if_reset", {31'd0, if_reset}, {31'd0, e_rst});
    chk("if_halt", {31'd0, if_halt}, {31'd0, e_halt});
    chk("if_ctrl_branch", {31'd0, if_ctrl_branch}, {31'd0, e_br});
    chk("if_take_branch", {31'd0, if_take_branch}, {31'd0, e_br});
    if (e_rst || e_br) chk("if_addr", {28'd0, if_addr}, {28'd0, e_addr});
    chk("busy", {31'd0, busy}, {31'd0, e_busy});
    chk("done", {31'd0, done}, {31'd0, e_done});
    chk("cycle_count", {29'd0, cycle_count}, m_runs);
    chk("pc", {28'd0, pc_cur}, {28'd0, m_pc});
  endtask

  task automatic drive(input logic r, input logic st, input logic [3:0] sa,
                       input logic bv, input logic bt, input logic [3:0] tg,
                       input logic sl, input logic hi);
    reset = r; start = st; start_addr = sa; br_valid = bv; br_taken = bt;
    br_target = tg; stall = sl; halt_inst = hi;
    #1;
  endtask

  task automatic advance();
    model_step();
    @(negedge clk);
  endtask

  typedef struct {
    logic       rst, st; logic [3:0] sa; logic bv, bt; logic [3:0] tg; logic sl, hi;
    logic [3:0] pc; logic busy, done; logic [2:0] cnt;
  } vec_t;

  function automatic vec_t mk(int rst, int st, int sa, int bv, int bt, int tg, int sl, int hi,
                              int pc, int bsy, int dn, int cnt);
    vec_t v;
    v.rst = rst[0]; v.st = st[0]; v.sa = sa[3:0]; v.bv = bv[0]; v.bt = bt[0];
    v.tg = tg[3:0]; v.sl = sl[0]; v.hi = hi[0];
    v.pc = pc[3:0]; v.busy = bsy[0]; v.done = dn[0]; v.cnt = cnt[2:0];
    return v;
  endfunction

  vec_t tbl[25];

  initial begin
    //            rst st sa bv bt tg sl hi   pc bsy dn cnt
    tbl[0]  = mk(0, 1, 5, 0, 0, 0, 0, 0,    0, 0, 0, 0);
    tbl[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0,    0, 1, 0, 0);
    tbl[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0,    5, 1, 0, 0);
    tbl[3]  = mk(0, 0, 0, 0, 0, 0, 0, 0,    6, 1, 0, 1);
    tbl[4]  = mk(0, 0, 0, 1, 1, 2, 0, 0,    7, 1, 0, 2);
    tbl[5]  = mk(0, 0, 0, 0, 0, 0, 0, 0,    2, 1, 0, 3);
    tbl[6]  = mk(0, 0, 0, 1, 1, 9, 1, 0,    3, 1, 0, 4);
    tbl[7]  = mk(0, 0, 0, 1, 1, 12, 1, 0,   3, 1, 0, 5);
    tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 0,    3, 1, 0, 6);
    tbl[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0,    3, 1, 0, 7);
    tbl[10] = mk(0, 0, 0, 0, 0, 0, 0, 0,    12, 1, 0, 7);
    tbl[11] = mk(0, 0, 0, 1, 1, 3, 0, 0,    13, 1, 0, 7);
    tbl[12] = mk(0, 0, 0, 0, 0, 0, 0, 0,    3, 1, 0, 7);
    tbl[13] = mk(0, 0, 0, 1, 1, 0, 0, 1,    4, 1, 0, 7);
    tbl[14] = mk(0, 0, 0, 0, 0, 0, 0, 0,    4, 0, 1, 7);
    tbl[15] = mk(0, 1, 1, 0, 0, 0, 0, 0,    4, 0, 1, 7);
    tbl[16] = mk(0, 0, 0, 0, 0, 0, 0, 0,    4, 1, 0, 0);
    tbl[17] = mk(0, 0, 0, 0, 0, 0, 0, 0,    1, 1, 0, 0);
    tbl[18] = mk(0, 0, 0, 1, 1, 10, 1, 0,   2, 1, 0, 1);
    tbl[19] = mk(1, 0, 0, 0, 0, 0, 0, 0,    2, 1, 0, 2);
    tbl[20] = mk(0, 1, 6, 0, 0, 0, 0, 0,    0, 0, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, 0, 0, 0, 0,    0, 1, 0, 0);
    tbl[22] = mk(0, 1, 3, 0, 0, 0, 0, 0,    6, 1, 0, 0);
    tbl[23] = mk(0, 0, 0, 1, 0, 0, 0, 0,    7, 1, 0, 1);
    tbl[24] = mk(0, 0, 0, 0, 0, 0, 0, 0,    8, 1, 0, 2);

    // Reset state, observed while reset is still asserted.
    drive(1, 0, 4'd9, 0, 0, 4'd0, 0, 0);
    @(negedge clk);
    @(negedge clk);
    #1;
    chk("rst_if_reset", {31'd0, if_reset}, 32'd1);
    chk("rst_if_addr", {28'd0, if_addr}, 32'd0);
    chk("rst_if_halt", {31'd0, if_halt}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_cycle_count", {29'd0, cycle_count}, 32'd0);
    chk("rst_pc", {28'd0, pc_cur}, 32'd0);
    advance();

    // Directed table: boot, branch, held redirect, halt, restart, saturation, mid-run reset.
    for (int i = 0; i < 25; i++) begin
      drive(tbl[i].rst, tbl[i].st, tbl[i].sa, tbl[i].bv, tbl[i].bt, tbl[i].tg,
            tbl[i].sl, tbl[i].hi);
      check_model();
      chk($sformatf("vec%0d_pc", i), {28'd0, pc_cur}, {28'd0, tbl[i].pc});
      chk($sformatf("vec%0d_busy", i), {31'd0, busy}, {31'd0, tbl[i].busy});
      chk($sformatf("vec%0d_done", i), {31'd0, done}, {31'd0, tbl[i].done});
      chk($sformatf("vec%0d_cnt", i), {29'd0, cycle_count}, {29'd0, tbl[i].cnt});
      advance();
    end

    // Hand sequence: held redirect issued as soon as the stall drops.
    drive(0, 0, 0, 1, 1, 4'd11, 1, 0); check_model(); advance();
    drive(0, 0, 0, 0, 0, 4'd0, 0, 0);
    chk("held_issue_branch", {31'd0, if_ctrl_branch}, 32'd1);
    chk("held_issue_addr", {28'd0, if_addr}, 32'd11);
    check_model(); advance();
    drive(0, 0, 0, 0, 0, 4'd0, 0, 0);
    chk("held_pc", {28'd0, pc_cur}, 32'd11);
    check_model(); advance();

    // Randomized traffic against the model.
    for (int n = 0; n < 600; n++) begin
      drive(($urandom_range(0, 99) < 2), ($urandom_range(0, 99) < 12),
            4'($urandom_range(0, 15)), ($urandom_range(0, 99) < 35),
            ($urandom_range(0, 99) < 60), 4'($urandom_range(0, 15)),
            ($urandom_range(0, 99) < 30), ($urandom_range(0, 99) < 4));
      check_model();
      advance();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
